edge_gen: RTL and testbench



---
 rtl/edge_gen_if.sv | 26 ++
 rtl/edge_gen.sv | 115 +++++++++++
 tb/tb_edge_gen.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/edge_gen_if.sv
// Command/status bundle for the programmable edge/pulse generator.
interface edge_gen_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned REP_W = 8
);
    logic             start_i;
    logic [CNT_W-1:0] high_len_i;
    logic [CNT_W-1:0] low_len_i;
    logic [REP_W-1:0] rep_i;
    logic             abort_i;
    logic             busy_o;
    logic             wave_o;
    logic             rise_o;
    logic             fall_o;
    logic             done_o;

    modport master (
        output start_i, high_len_i, low_len_i, rep_i, abort_i,
        input  busy_o, wave_o, rise_o, fall_o, done_o
    );

    modport slave (
        input  start_i, high_len_i, low_len_i, rep_i, abort_i,
        output busy_o, wave_o, rise_o, fall_o, done_o
    );
endinterface

// File: rtl/edge_gen.sv
// Programmable edge/pulse generator: R pulses of H high / L low cycles with
// registered rise/fall strobes and a done strobe on the final cycle.
module edge_gen #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned REP_W = 8
) (
    input logic      clk,
    input logic      reset,
    edge_gen_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hlen_q, hlen_d;
    logic [CNT_W-1:0] llen_q, llen_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             busy_q, busy_d;
    logic             wave_q, wave_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             done_q, done_d;

    // Lengths are stored as (len-1) with 0 clamped to 1, so counters never wrap.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hlen_q  <= '0;
            llen_q  <= '0;
            rep_q   <= '0;
            busy_q  <= 1'b0;
            wave_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hlen_q  <= hlen_d;
            llen_q  <= llen_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
            wave_q  <= wave_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hlen_d  = hlen_q;
        llen_d  = llen_q;
        rep_d   = rep_q;

        case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    hlen_d  = len_m1(bus.high_len_i);
                    llen_d  = len_m1(bus.low_len_i);
                    rep_d   = (bus.rep_i == '0) ? '0 : bus.rep_i - REP_W'(1);
                    cnt_d   = len_m1(bus.high_len_i);
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d   = llen_q;
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOW: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    if (rep_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        rep_d   = rep_q - REP_W'(1);
                        cnt_d   = hlen_q;
                        state_d = HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes derive from the level change, so a loopback detector matches exactly.
        busy_d = (state_d != IDLE);
        wave_d = (state_d == HIGH);
        rise_d = wave_d & ~wave_q;
        fall_d = ~wave_d & wave_q;
        done_d = (state_d == LOW) && (cnt_d == '0) && (rep_d == '0);
    end

    assign bus.busy_o = busy_q;
    assign bus.wave_o = wave_q;
    assign bus.rise_o = rise_q;
    assign bus.fall_o = fall_q;
    assign bus.done_o = done_q;
endmodule

// File: tb/tb_edge_gen.sv
// Directed scoreboard bench for edge_gen: expected {busy,wave,rise,fall,done}
// per cycle are queued at stimulus time and compared each cycle.
module tb_edge_gen;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned REP_W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    edge_gen_if #(.CNT_W(CNT_W), .REP_W(REP_W)) bus ();
    edge_gen #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [4:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       wave_prev = 1'b0;
    string      tag = "reset";

    // One cycle: compare outputs against the scoreboard (empty queue means idle).
    task automatic tick();
        logic       rst_e;
        logic [4:0] got;
        logic [4:0] exp;
        logic [1:0] det;
        rst_e = reset;
        @(negedge clk);
        got = {bus.busy_o, bus.wave_o, bus.rise_o, bus.fall_o, bus.done_o};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d bwrfd: got %b want %b", tag, cyc, got, exp);
        end
        if (!rst_e) begin
            det = {bus.wave_o & ~wave_prev, ~bus.wave_o & wave_prev};
            checks++;
            assert ({bus.rise_o, bus.fall_o} === det) else begin
                errors++;
                $error("FAIL %s_loopback cyc=%0d rise/fall: got %b want %b",
                       tag, cyc, {bus.rise_o, bus.fall_o}, det);
            end
        end
        checks++;
        assert ((bus.done_o & ~bus.busy_o) === 1'b0) else begin
            errors++;
            $error("FAIL %s_done_idle cyc=%0d: got done=%b busy=%b want no done while idle",
                   tag, cyc, bus.done_o, bus.busy_o);
        end
        wave_prev = bus.wave_o;
        cyc++;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        while (exp_q.size() > 0) tick();
    endtask

    // Expected trace of a full sequence from its first busy cycle.
    task automatic push_seq(input int h, input int l, input int r);
        int hc;
        int lc;
        int rc;
        hc = (h == 0) ? 1 : h;
        lc = (l == 0) ? 1 : l;
        rc = (r == 0) ? 1 : r;
        for (int p = 0; p < rc; p++) begin
            for (int i = 0; i < hc; i++)
                exp_q.push_back({1'b1, 1'b1, 1'(i == 0), 1'b0, 1'b0});
            for (int j = 0; j < lc; j++)
                exp_q.push_back({1'b1, 1'b0, 1'b0, 1'(j == 0),
                                 1'((p == rc - 1) && (j == lc - 1))});
        end
    endtask

    task automatic set_cfg(input int h, input int l, input int r);
        bus.high_len_i = CNT_W'(h);
        bus.low_len_i  = CNT_W'(l);
        bus.rep_i      = REP_W'(r);
    endtask

    task automatic start_seq(input int h, input int l, input int r);
        push_seq(h, l, r);
        set_cfg(h, l, r);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        set_cfg(0, 0, 0);
        tick_n(3);
        reset = 1'b0;
        tick_n(7);

        tag = "basic_h3l2r1";
        start_seq(3, 2, 1);
        drain();
        tick_n(2);

        tag = "h1l1r3";
        start_seq(1, 1, 3);
        drain();
        tick();

        tag = "clamp_zero";
        start_seq(0, 0, 0);
        drain();
        tick();

        tag = "max_len";
        start_seq(255, 255, 2);
        drain();
        tick();

        tag = "max_rep";
        start_seq(1, 1, 255);
        drain();
        tick();

        tag = "ignore_busy";
        start_seq(4, 4, 2);
        tick_n(3);
        set_cfg(7, 9, 5);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        exp_q.push_back(5'b00000);
        push_seq(2, 3, 1);
        tick_n(11);
        tag = "restart";
        tick();
        set_cfg(2, 3, 1);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        drain();
        tick();

        tag = "abort_high";
        exp_q.push_back(5'b11100);
        exp_q.push_back(5'b11000);
        exp_q.push_back(5'b00010);
        set_cfg(4, 2, 1);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        tick_n(2);

        tag = "abort_low";
        exp_q.push_back(5'b11100);
        exp_q.push_back(5'b11000);
        exp_q.push_back(5'b10010);
        exp_q.push_back(5'b10000);
        exp_q.push_back(5'b00000);
        set_cfg(2, 3, 2);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick_n(3);
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        tick_n(2);

        tag = "abort_start_idle";
        set_cfg(3, 3, 1);
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        tick_n(3);

        tag = "reset_mid_high";
        exp_q.push_back(5'b11100);
        exp_q.push_back(5'b11000);
        set_cfg(5, 2, 1);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        exp_q.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick_n(3);

        tag = "after_reset";
        start_seq(2, 1, 2);
        drain();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
